// File: rtl/run_dump_ctrl.sv
// rtl/run_dump_ctrl.sv - CPU run/freeze sequencer with handshaked register-file dump
// Optional feature macro: RUN_DUMP_HALT_EN (adds halt_i, lets the CPU end a run early)
module run_dump_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int RUN_CYCLES = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              cpu_rst_o,
  output logic              cpu_run_o,
`ifdef RUN_DUMP_HALT_EN
  input  logic              halt_i,
`endif
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       cycle_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [31:0]       RUN_LAST = 32'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                halt_req;

  // Early-stop request from the CPU; constant zero when the halt feature is not built
`ifdef RUN_DUMP_HALT_EN
  assign halt_req = halt_i;
`else
  assign halt_req = 1'b0;
`endif

  // State and datapath registers; reset returns everything to idle values at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Next-state and datapath update: run for a fixed count, then LOAD/SEND each entry
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          cycle_cnt_d = '0;
          idx_d       = '0;
        end
      end
      ST_RUN: begin
        // The last RUN cycle (or the halting one) is still counted
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if ((cycle_cnt_q == RUN_LAST) || halt_req) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // CPU is frozen here, so the combinational read is stable
        dump_data_d = rf_data_i;
        dump_idx_d  = idx_q;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (dump_ready_i) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU stays out of reset (but clock-gated) while its registers are dumped
  assign cpu_rst_o    = (state_q == ST_RUN) || (state_q == ST_LOAD) || (state_q == ST_SEND);
  assign cpu_run_o    = (state_q == ST_RUN);
  assign busy_o       = cpu_rst_o;
  assign done_o       = (state_q == ST_DONE);
  assign dump_valid_o = (state_q == ST_SEND);
  assign rf_addr_o    = idx_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;
  assign cycle_cnt_o  = cycle_cnt_q;

endmodule
